// File: rtl/game_pkg.sv
// Shared definitions for the game timer: difficulty mode encodings, the
// timer state enum and an elaboration-time binary to two-digit BCD helper.
package game_pkg;

    localparam logic [1:0] MODE_EASY     = 2'b00;
    localparam logic [1:0] MODE_MED      = 2'b01;
    localparam logic [1:0] MODE_HARD     = 2'b10;
    localparam logic [1:0] MODE_PRACTICE = 2'b11;

    typedef enum logic [1:0] {
        ST_LOADED  = 2'b00,
        ST_RUN     = 2'b01,
        ST_PAUSE   = 2'b10,
        ST_EXPIRED = 2'b11
    } timer_state_t;

    // Binary seconds (clamped to 99) to packed BCD {tens, units}.
    function automatic logic [7:0] to_bcd8(input int unsigned v);
        int unsigned c;
        c = (v > 99) ? 99 : v;
        return {4'(c / 10), 4'(c % 10)};
    endfunction

endpackage

// File: rtl/game_timer_tick_gen.sv
// Pausable prescaler: counts enabled cycles and pulses tick for one cycle
// on the enabled cycle that reaches terminal count DIV-1. clr restarts the
// count from zero and suppresses any tick in that cycle.
module tick_gen #(
    parameter int DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Prescaler count: cleared on clr, advances and wraps on enabled cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == TERM) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = en && !clr && (cnt == TERM);

endmodule

// File: rtl/game_timer.sv
// Round countdown timer for the game controller. Loads a mode-dependent
// duration on reconfig, counts whole seconds down while enabled and holds a
// sticky timeout once the remaining time reaches zero. Remaining time is
// kept directly as two BCD digits for the seven-segment display.
// Optional feature macro: GAME_TIMER_WARN_EN adds the registered warn output.
module game_timer
    import game_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int SECS_M0   = 60,
    parameter int SECS_M1   = 45,
    parameter int SECS_M2   = 30,
    parameter int SECS_M3   = 20,
    parameter int WARN_SECS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       reconfig,
    input  logic       enable,
    input  logic [1:0] mode,
    output logic       timeout,
    output logic [7:0] secs_bcd,
    output logic       running
`ifdef GAME_TIMER_WARN_EN
    ,
    output logic       warn
`endif
);

    localparam int TICK_DIV = CLK_HZ;

    localparam logic [7:0] BCD_M0 = to_bcd8(SECS_M0);
    localparam logic [7:0] BCD_M1 = to_bcd8(SECS_M1);
    localparam logic [7:0] BCD_M2 = to_bcd8(SECS_M2);
    localparam logic [7:0] BCD_M3 = to_bcd8(SECS_M3);
`ifdef GAME_TIMER_WARN_EN
    localparam logic [7:0] WARN_BCD = to_bcd8(WARN_SECS);
`endif

    timer_state_t state, state_nx;
    logic [7:0]   rem_nx;
    logic         timeout_nx;
    logic         running_nx;
    logic         tick;
    logic         pre_en;
`ifdef GAME_TIMER_WARN_EN
    logic         warn_nx;
`endif

    // Round duration for the selected difficulty, already in BCD.
    function automatic logic [7:0] mode_secs(input logic [1:0] m);
        case (m)
            MODE_EASY:  return BCD_M0;
            MODE_MED:   return BCD_M1;
            MODE_HARD:  return BCD_M2;
            default:    return BCD_M3;
        endcase
    endfunction

    // One-second BCD decrement: units borrow from tens, 00 saturates.
    function automatic logic [7:0] bcd_dec(input logic [7:0] d);
        if (d == 8'h00) begin
            return 8'h00;
        end else if (d[3:0] == 4'd0) begin
            return {d[7:4] - 4'd1, 4'd9};
        end else begin
            return {d[7:4], d[3:0] - 4'd1};
        end
    endfunction

    // The prescaler runs on every enabled cycle outside EXPIRED, including
    // the LOADED->RUN and PAUSE->RUN cycles, so the held phase is kept.
    assign pre_en = enable && (state != ST_EXPIRED);

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (reconfig),
        .en   (pre_en),
        .tick (tick)
    );

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_LOADED;
            secs_bcd <= 8'h00;
            timeout  <= 1'b0;
            running  <= 1'b0;
`ifdef GAME_TIMER_WARN_EN
            warn     <= 1'b0;
`endif
        end else begin
            state    <= state_nx;
            secs_bcd <= rem_nx;
            timeout  <= timeout_nx;
            running  <= running_nx;
`ifdef GAME_TIMER_WARN_EN
            warn     <= warn_nx;
`endif
        end
    end

    // Next-state logic; reconfig overrides everything.
    always_comb begin
        state_nx = state;
        if (reconfig) begin
            state_nx = ST_LOADED;
        end else begin
            case (state)
                ST_LOADED: begin
                    if (enable) begin
                        state_nx = (secs_bcd == 8'h00) ? ST_EXPIRED : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        state_nx = ST_PAUSE;
                    end else if (tick && secs_bcd == 8'h01) begin
                        state_nx = ST_EXPIRED;
                    end
                end
                ST_PAUSE: begin
                    if (enable) begin
                        state_nx = (tick && secs_bcd == 8'h01) ? ST_EXPIRED : ST_RUN;
                    end
                end
                default: state_nx = ST_EXPIRED;
            endcase
        end
    end

    // Output values for the next edge: remaining time, timeout, running, warn.
    always_comb begin
        rem_nx     = secs_bcd;
        timeout_nx = timeout;
        if (reconfig) begin
            rem_nx     = mode_secs(mode);
            timeout_nx = 1'b0;
        end else if (state_nx == ST_EXPIRED) begin
            rem_nx     = 8'h00;
            timeout_nx = 1'b1;
        end else if ((state == ST_RUN || state == ST_PAUSE) && tick) begin
            rem_nx = bcd_dec(secs_bcd);
        end
        running_nx = (state_nx == ST_RUN);
`ifdef GAME_TIMER_WARN_EN
        warn_nx = (state_nx == ST_RUN || state_nx == ST_PAUSE) &&
                  (rem_nx != 8'h00) && (rem_nx <= WARN_BCD);
`endif
    end

endmodule

// File: tb/tb_game_timer.sv
// Bench for game_timer: two instances (short and 12 s easy round) driven by
// shared stimulus, each compared every cycle against a seconds-level model.
module tb_game_timer;

    localparam int DIV  = 4;
    localparam int WSEC = 10;
    localparam int P_LOAD = 0, P_RUN = 1, P_PAUSE = 2, P_EXP = 3;

    typedef struct packed {
        int   rem;
        int   acc;
        int   ph;
        logic to;
    } mdl_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       reconfig = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'b00;

    logic       timeout_a, running_a, timeout_b, running_b;
    logic [7:0] secs_a, secs_b;
`ifdef GAME_TIMER_WARN_EN
    logic       warn_a, warn_b;
`endif

    int checks = 0;
    int errors = 0;

    mdl_t ma, mb;

    always #5 clk = ~clk;

    game_timer #(
        .CLK_HZ(DIV), .SECS_M0(3), .SECS_M1(2), .SECS_M2(1), .SECS_M3(0), .WARN_SECS(WSEC)
    ) dut_a (
        .clk(clk), .rst(rst), .reconfig(reconfig), .enable(enable), .mode(mode),
        .timeout(timeout_a), .secs_bcd(secs_a), .running(running_a)
`ifdef GAME_TIMER_WARN_EN
        , .warn(warn_a)
`endif
    );

    game_timer #(
        .CLK_HZ(DIV), .SECS_M0(12), .SECS_M1(2), .SECS_M2(1), .SECS_M3(0), .WARN_SECS(WSEC)
    ) dut_b (
        .clk(clk), .rst(rst), .reconfig(reconfig), .enable(enable), .mode(mode),
        .timeout(timeout_b), .secs_bcd(secs_b), .running(running_b)
`ifdef GAME_TIMER_WARN_EN
        , .warn(warn_b)
`endif
    );

    // One clock of the timer in seconds-and-enabled-cycles terms.
    function automatic mdl_t step(mdl_t m, logic rc, logic en, logic [1:0] md,
                                  int s0, int s1, int s2, int s3);
        mdl_t n;
        n = m;
        if (rc) begin
            n.rem = (md == 2'd0) ? s0 : (md == 2'd1) ? s1 : (md == 2'd2) ? s2 : s3;
            n.acc = 0;
            n.to  = 1'b0;
            n.ph  = P_LOAD;
        end else if (m.ph != P_EXP) begin
            if (en) begin
                if (m.ph == P_LOAD && m.rem == 0) begin
                    n.ph = P_EXP;
                    n.to = 1'b1;
                end else begin
                    n.ph  = P_RUN;
                    n.acc = m.acc + 1;
                    if (n.acc == DIV) begin
                        n.acc = 0;
                        if (m.ph != P_LOAD) begin
                            n.rem = m.rem - 1;
                            if (n.rem == 0) begin
                                n.ph = P_EXP;
                                n.to = 1'b1;
                            end
                        end
                    end
                end
            end else if (m.ph == P_RUN) begin
                n.ph = P_PAUSE;
            end
        end
        return n;
    endfunction

    function automatic logic [7:0] bcd(int r);
        return 8'(((r / 10) << 4) | (r % 10));
    endfunction

    function automatic logic mwarn(mdl_t m);
        return (m.ph == P_RUN || m.ph == P_PAUSE) && m.rem > 0 && m.rem <= WSEC;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model update.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ma <= '0;
            mb <= '0;
        end else begin
            ma <= step(ma, reconfig, enable, mode, 3, 2, 1, 0);
            mb <= step(mb, reconfig, enable, mode, 12, 2, 1, 0);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("a_secs", 32'(secs_a), 32'(bcd(ma.rem)));
            chk("a_timeout", 32'(timeout_a), 32'(ma.to));
            chk("a_running", 32'(running_a), 32'(ma.ph == P_RUN));
            chk("b_secs", 32'(secs_b), 32'(bcd(mb.rem)));
            chk("b_timeout", 32'(timeout_b), 32'(mb.to));
            chk("b_running", 32'(running_b), 32'(mb.ph == P_RUN));
`ifdef GAME_TIMER_WARN_EN
            chk("a_warn", 32'(warn_a), 32'(mwarn(ma)));
            chk("b_warn", 32'(warn_b), 32'(mwarn(mb)));
`endif
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_timeout(input int maxc);
        int k;
        k = 0;
        while (!timeout_a && k < maxc) begin
            @(negedge clk);
            k++;
        end
        chk("wait_timeout", 32'(timeout_a), 32'd1);
    endtask

    initial begin
        cyc(3);
        chk("rst_secs", 32'(secs_a), 32'h00);
        chk("rst_timeout", 32'(timeout_a), 32'd0);
        rst = 1'b1;

        // Idle after reset.
        cyc(20);
        chk("idle_secs", 32'(secs_a), 32'h00);
        chk("idle_timeout", 32'(timeout_a), 32'd0);
        chk("idle_running", 32'(running_a), 32'd0);

        // Full countdown in mode 00; dut_b exercises the BCD borrow.
        reconfig = 1'b1; mode = 2'b00;
        cyc(1);
        chk("load_secs", 32'(secs_a), 32'h03);
        chk("load_b_secs", 32'(secs_b), 32'h12);
        reconfig = 1'b0; enable = 1'b1;
        cyc(4);
        chk("cd_02", 32'(secs_a), 32'h02);
        chk("cd_running", 32'(running_a), 32'd1);
        chk("borrow_11", 32'(secs_b), 32'h11);
        cyc(4);
        chk("cd_01", 32'(secs_a), 32'h01);
        chk("borrow_10", 32'(secs_b), 32'h10);
`ifdef GAME_TIMER_WARN_EN
        chk("warn_rise", 32'(warn_b), 32'd1);
`endif
        cyc(4);
        chk("cd_00", 32'(secs_a), 32'h00);
        chk("cd_timeout", 32'(timeout_a), 32'd1);
        chk("borrow_09", 32'(secs_b), 32'h09);
        cyc(50);
        chk("sticky_timeout", 32'(timeout_a), 32'd1);
        chk("b_expired", 32'(timeout_b), 32'd1);
`ifdef GAME_TIMER_WARN_EN
        chk("warn_fall", 32'(warn_b), 32'd0);
`endif

        // Pause keeps the prescaler phase.
        reconfig = 1'b1; mode = 2'b00; enable = 1'b0;
        cyc(1);
        reconfig = 1'b0; enable = 1'b1;
        cyc(2);
        enable = 1'b0;
        cyc(7);
        chk("pause_secs", 32'(secs_a), 32'h03);
        chk("pause_running", 32'(running_a), 32'd0);
        enable = 1'b1;
        cyc(1);
        chk("resume_1", 32'(secs_a), 32'h03);
        cyc(1);
        chk("resume_2", 32'(secs_a), 32'h02);

        // Expire, then reconfig to mode 01.
        wait_timeout(40);
        reconfig = 1'b1; mode = 2'b01; enable = 1'b0;
        cyc(1);
        chk("rc_timeout", 32'(timeout_a), 32'd0);
        chk("rc_secs", 32'(secs_a), 32'h02);
        reconfig = 1'b0; enable = 1'b1;
        cyc(4);
        chk("rc_cd_01", 32'(secs_a), 32'h01);
        cyc(4);
        chk("rc_cd_00", 32'(secs_a), 32'h00);
        chk("rc_cd_to", 32'(timeout_a), 32'd1);

        // Zero-length round.
        reconfig = 1'b1; mode = 2'b11; enable = 1'b0;
        cyc(1);
        chk("m3_to_lo", 32'(timeout_a), 32'd0);
        reconfig = 1'b0; enable = 1'b1;
        cyc(1);
        chk("m3_to_hi", 32'(timeout_a), 32'd1);
        chk("m3_running", 32'(running_a), 32'd0);

        // reconfig held with enable: no counting.
        reconfig = 1'b1; mode = 2'b00; enable = 1'b1;
        cyc(6);
        chk("rcen_secs", 32'(secs_a), 32'h03);
        chk("rcen_running", 32'(running_a), 32'd0);
        reconfig = 1'b0;
        cyc(4);
        chk("rcen_after", 32'(secs_a), 32'h02);

        // Asynchronous reset mid-cycle.
        cyc(1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_secs", 32'(secs_a), 32'h00);
        chk("arst_b_secs", 32'(secs_b), 32'h00);
        chk("arst_running", 32'(running_a), 32'd0);
        chk("arst_timeout", 32'(timeout_a), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reconfig = ($urandom % 16) == 0;
            enable   = ($urandom % 4) != 0;
            mode     = 2'($urandom);
            rst      = ($urandom % 400) != 0;
        end
        @(negedge clk);
        rst = 1'b1;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
